// File: rtl/leb128_pkg.sv
// Shared widths and byte-slicing helpers for the signed LEB128 decoder.
// Optional error flag is controlled by LEB128_UNPACK_I64_ERR_EN in the users.
package leb128_pkg;
    localparam int MAX_BYTES = 10;
    localparam int OUT_W     = 64;
    localparam int LEN_W     = 4;
    localparam int IN_W      = 8 * MAX_BYTES;
    localparam int CONT_BIT  = 7;
    localparam int PAY_W     = 7;
    localparam int SIGN_BIT  = 6;

    // Byte 0 is the first byte on the wire and sits in the top of the window.
    function automatic logic [7:0] get_byte(input logic [IN_W-1:0] v, input int k);
        return v[IN_W-1-8*k -: 8];
    endfunction
endpackage

// File: rtl/leb128_i64_comb.sv
// Combinational sLEB128 decode of an 80-bit window into value, length and
// (with LEB128_UNPACK_I64_ERR_EN) an error flag for overlong/non-canonical input.
module leb128_i64_comb
    import leb128_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
    output logic [LEN_W-1:0] len
`ifdef LEB128_UNPACK_I64_ERR_EN
    ,
    output logic             err
`endif
);
    localparam logic [OUT_W-1:0] ONES = '1;

    always_comb begin
        logic       run;
        logic [7:0] bk;
        run = 1'b1;
        bk  = '0;
        out = '0;
        len = '0;
`ifdef LEB128_UNPACK_I64_ERR_EN
        err = 1'b0;
`endif
        // run stays 1 only while every earlier byte continued, so bytes past the
        // terminator are gated by a known-0 select and never reach the outputs.
        for (int k = 0; k < MAX_BYTES; k++) begin
            bk = get_byte(in, k);
            if (run) begin
                if (k == MAX_BYTES - 1) begin
                    out[OUT_W-1] = bk[0];
                    len          = LEN_W'(MAX_BYTES);
`ifdef LEB128_UNPACK_I64_ERR_EN
                    err = bk[CONT_BIT] | (bk[SIGN_BIT:1] != {SIGN_BIT{bk[0]}});
`endif
                end else begin
                    out = out | (OUT_W'(bk[PAY_W-1:0]) << (PAY_W * k));
                    if (!bk[CONT_BIT]) begin
                        len = LEN_W'(k + 1);
                        if (bk[SIGN_BIT])
                            out = out | (ONES << (PAY_W * (k + 1)));
                    end
                end
            end
            run = run & bk[CONT_BIT];
        end
    end
endmodule

// File: rtl/leb128_unpack_i64.sv
// Registered sLEB128 decoder: one result per accepted in_valid, latency 1.
// Define LEB128_UNPACK_I64_ERR_EN to add the registered err output.
module leb128_unpack_i64
    import leb128_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out,
    output logic [LEN_W-1:0]  len
`ifdef LEB128_UNPACK_I64_ERR_EN
    ,
    output logic              err
`endif
);
    logic [OUT_W-1:0] dec_out;
    logic [LEN_W-1:0] dec_len;
`ifdef LEB128_UNPACK_I64_ERR_EN
    logic             dec_err;
`endif

    leb128_i64_comb u_dec (
        .in  (in),
        .out (dec_out),
        .len (dec_len)
`ifdef LEB128_UNPACK_I64_ERR_EN
        ,
        .err (dec_err)
`endif
    );

    // Data registers only load on a valid input, so out/len hold through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            len       <= '0;
`ifdef LEB128_UNPACK_I64_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= dec_out;
                len <= dec_len;
`ifdef LEB128_UNPACK_I64_ERR_EN
                err <= dec_err;
`endif
            end
        end
    end
endmodule

// File: tb/tb_leb128_unpack_i64.sv
// Scoreboard bench for leb128_unpack_i64; err checked when LEB128_UNPACK_I64_ERR_EN is defined.
module tb_leb128_unpack_i64;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [79:0] din = '0;
    logic        out_valid;
    logic [63:0] out;
    logic [3:0]  len;
`ifdef LEB128_UNPACK_I64_ERR_EN
    logic        err;
`endif

    typedef struct packed {
        logic [63:0] o;
        logic [3:0]  l;
        logic        e;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    leb128_unpack_i64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .out_valid (out_valid),
        .out       (out),
        .len       (len)
`ifdef LEB128_UNPACK_I64_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: find terminator, assemble payload, then sign-extend by shifting up and back.
    function automatic exp_t model(input logic [79:0] v);
        exp_t r;
        int t;
        int sh;
        logic [63:0] acc;
        logic signed [63:0] tmp;
        logic [7:0] b9;
        t = 9;
        for (int k = 0; k < 10; k++)
            if (v[79-8*k] == 1'b0) begin t = k; break; end
        acc = '0;
        for (int k = 0; k <= t; k++)
            acc = acc | (64'(v[78-8*k -: 7]) << (7 * k));
        sh = 7 * (t + 1);
        if (sh < 64) begin
            tmp = $signed(acc << (64 - sh));
            acc = 64'(tmp >>> (64 - sh));
        end
        b9  = v[7:0];
        r.o = acc;
        r.l = 4'(t + 1);
        r.e = (t == 9) && (b9[7] || (b9[6:1] != {6{b9[0]}}));
        return r;
    endfunction

    task automatic send(input logic [79:0] v, input exp_t e);
        in_valid = 1'b1;
        din      = v;
        sb.push_back(e);
        last = e;
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out", out, e.o);
                chk("len", 64'(len), 64'(e.l));
`ifdef LEB128_UNPACK_I64_ERR_EN
                chk("err", 64'(err), 64'(e.e));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [79:0] v;
        exp_t e;
        int t;

        // Reset values
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out", out, 64'd0);
        chk("rst_len", 64'(len), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, back-to-back
        send({8'h01, {72{1'bx}}},        '{64'd1, 4'd1, 1'b0});
        send(80'hffffffffffffffffff01,   '{64'hffffffffffffffff, 4'd10, 1'b1});
        send(80'h808080800cbc0b000000,   '{64'h00000000c0000000, 4'd5, 1'b0});
        send({8'h7f, 72'h0},             '{64'hffffffffffffffff, 4'd1, 1'b0});
        send({8'h3f, 72'h0},             '{64'd63, 4'd1, 1'b0});
        send({10{8'hff}},                '{64'hffffffffffffffff, 4'd10, 1'b1});
        send({{9{8'h80}}, 8'h00},        '{64'd0, 4'd10, 1'b0});
        send({{9{8'hff}}, 8'h7f},        '{64'hffffffffffffffff, 4'd10, 1'b0});
        send({8'hc0, 8'h00, 64'h0},      '{64'd64, 4'd2, 1'b0});
        send({8'h80, 8'h7f, 64'hdead},   '{64'hffffffffffffff80, 4'd2, 1'b0});

        // Idle: out_valid drops, data holds
        in_valid = 1'b0;
        din      = '1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("hold_out", out, last.o);
        chk("hold_len", 64'(len), 64'(last.l));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        // Random vectors with garbage after the terminator
        for (int n = 0; n < 40; n++) begin
            t = $urandom_range(0, 9);
            for (int k = 0; k < 10; k++) begin
                v[79-8*k -: 8] = 8'($urandom);
                if (k < t) v[79-8*k] = 1'b1;
                else if (k == t && t < 9) v[79-8*k] = 1'b0;
            end
            e = model(v);
            send(v, e);
        end
        in_valid = 1'b0;
        @(negedge clk);

        // Async reset mid-cycle, with a pending input that must be discarded
        in_valid = 1'b1;
        din      = {8'h05, 72'h0};
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out", out, 64'd0);
        chk("arst_len", 64'(len), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_out", out, 64'd0);
        send({8'h05, 72'h0}, '{64'd5, 4'd1, 1'b0});
        in_valid = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
